// File: rtl/wb_button_pkg.sv
// Shared types for the Wishbone debug-button device: address map and response kinds.
package wb_button_pkg;

  localparam int unsigned ADR_WIDTH = 3;

  typedef enum logic [ADR_WIDTH-1:0] {
    ADR_STATUS = 3'd0,
    ADR_EVENT  = 3'd1,
    ADR_LED    = 3'd2,
    ADR_COUNT  = 3'd3
  } reg_addr_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_e;

endpackage

// File: rtl/wb_button_device_if.sv
// Pipelined Wishbone link between the debug controller (master) and the button device (slave).
interface wb_button_device_if
  import wb_button_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = 8
);

  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [ADR_WIDTH-1:0] adr_i;
  logic [DAT_WIDTH-1:0] dat_i;
  logic [DAT_WIDTH-1:0] dat_o;
  logic                 ack_o;
  logic                 err_o;
  logic                 rty_o;
  logic                 stall_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o, rty_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o, rty_o, stall_o
  );

endinterface

// File: rtl/btn_conditioner.sv
// Two-flop synchroniser for raw buttons; optional per-bit debounce when WB_BTN_DEBOUNCE_EN is defined.
module btn_conditioner #(
`ifdef WB_BTN_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 16,
`endif
  parameter int unsigned N_BTN = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] lvl
);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_i;
      sync2 <= sync1;
    end
  end

`ifdef WB_BTN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [N_BTN-1:0] lvl_q;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (sync2[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          lvl_q[i] <= sync2[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync2;
`endif

endmodule

// File: rtl/wb_button_device.sv
// Wishbone responder exposing button level, sticky edge flags, edge count and an LED register.
// Build option: WB_BTN_DEBOUNCE_EN enables per-button debounce ahead of edge detection.
module wb_button_device
  import wb_button_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = 8,
`ifdef WB_BTN_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 16,
`endif
  parameter int unsigned N_BTN = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_button_device_if.slave    bus,
  input  logic [N_BTN-1:0]     btn_i,
  output logic [DAT_WIDTH-1:0] led_o
);

  localparam int unsigned SUM_W = DAT_WIDTH + 1;

  logic [N_BTN-1:0]     lvl;
  logic [N_BTN-1:0]     lvl_prev;
  logic [N_BTN-1:0]     edges;
  logic [N_BTN-1:0]     event_q, event_d, clr_mask;
  logic [DAT_WIDTH-1:0] count_q, count_d;
  logic [DAT_WIDTH-1:0] led_q, led_d;
  logic [DAT_WIDTH-1:0] rdata_q, rdata_d;
  logic [SUM_W-1:0]     count_sum;
  logic                 stall_q;
  logic                 accept;
  logic                 bad;
  logic                 ack;
  logic                 err;
  rsp_e                 rsp_q, rsp_d;

  btn_conditioner #(
`ifdef WB_BTN_DEBOUNCE_EN
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`endif
    .N_BTN(N_BTN)
  ) u_cond (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .btn_i(btn_i),
    .lvl  (lvl)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_q    <= RSP_NONE;
      stall_q  <= 1'b0;
      rdata_q  <= '0;
      lvl_prev <= '0;
      event_q  <= '0;
      count_q  <= '0;
      led_q    <= '0;
    end else begin
      rsp_q    <= rsp_d;
      stall_q  <= accept & bus.we_i;
      rdata_q  <= rdata_d;
      lvl_prev <= lvl;
      event_q  <= event_d;
      count_q  <= count_d;
      led_q    <= led_d;
    end
  end

  // Request decode, register updates and next response
  always_comb begin
    rsp_d    = RSP_NONE;
    led_d    = led_q;
    clr_mask = '0;
    rdata_d  = '0;
    accept   = bus.cyc_i & bus.stb_i & ~stall_q;
    bad      = bus.adr_i[ADR_WIDTH-1] |
               (bus.we_i & ((bus.adr_i == ADR_STATUS) | (bus.adr_i == ADR_COUNT)));
    edges    = lvl & ~lvl_prev;

    if (accept) begin
      rsp_d = bad ? RSP_ERR : RSP_ACK;
      if (!bad && bus.we_i) begin
        case (bus.adr_i)
          ADR_EVENT: clr_mask = bus.dat_i[N_BTN-1:0];
          ADR_LED:   led_d    = bus.dat_i;
          default:   ;
        endcase
      end else if (!bad) begin
        case (bus.adr_i)
          ADR_STATUS: rdata_d = DAT_WIDTH'(lvl);
          ADR_EVENT:  rdata_d = DAT_WIDTH'(event_q);
          ADR_LED:    rdata_d = led_q;
          ADR_COUNT:  rdata_d = count_q;
          default:    rdata_d = '0;
        endcase
      end
    end

    // New edges take priority over a same-cycle clear
    event_d = (event_q & ~clr_mask) | edges;

    count_sum = {1'b0, count_q};
    for (int i = 0; i < int'(N_BTN); i++) begin
      count_sum = count_sum + SUM_W'(edges[i]);
    end
    count_d = count_sum[DAT_WIDTH] ? '1 : count_sum[DAT_WIDTH-1:0];
  end

  // A master dropping cyc_i abandons the pending termination
  assign ack         = (rsp_q == RSP_ACK) & bus.cyc_i;
  assign err         = (rsp_q == RSP_ERR) & bus.cyc_i;
  assign bus.ack_o   = ack;
  assign bus.err_o   = err;
  assign bus.dat_o   = ack ? rdata_q : '0;
  assign bus.rty_o   = 1'b0;
  assign bus.stall_o = stall_q;
  assign led_o       = led_q;

endmodule
